mdu_divider: RTL and testbench

- Iterative restoring integer divider for the MIPS datapath. It is the inverse of the ALU's single-cycle MUL: it computes quotient and remainder for DIV/DIVU.
- Sits beside the ALU in the execute stage. The control unit launches it with start, stalls the pipeline while busy is high, and writes quotient/remainder to LO/HI when done pulses.
- Handles one quotient bit per cycle with a start/busy/done handshake.

---
 rtl/mdu_divider.sv | 151 +++++++++++++++
 tb/tb_mdu_divider.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_divider.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_divider
//  Description : Iterative restoring divider (DIV/DIVU), one quotient bit per
//                cycle, start/busy/done handshake, results to LO/HI.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int c_cnt_w = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ZERO = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic               w_launch;

  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvs;
  logic               r_neg_q;
  logic               r_neg_r;

  logic               w_dvd_neg;
  logic               w_dvs_neg;
  logic [WIDTH-1:0]   w_dvd_mag;
  logic [WIDTH-1:0]   w_dvs_mag;
  logic               w_dvs_zero;

  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nx;
  logic [WIDTH-1:0]   w_quo_nx;
  logic               w_cnt_last;

  // Operand magnitudes for the unsigned core; signs are reapplied at the end.
  assign w_dvd_neg  = is_signed & dividend[WIDTH-1];
  assign w_dvs_neg  = is_signed & divisor[WIDTH-1];
  assign w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_mag  = w_dvs_neg ? -divisor : divisor;
  assign w_dvs_zero = (divisor == '0);

  // Shifted partial remainder is WIDTH+1 bits so a divisor with its MSB set
  // still compares correctly; the borrow bit of the subtraction is the result.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_dvs};
  assign w_ge       = ~w_diff[WIDTH];
  assign w_rem_nx   = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nx   = {r_quo[WIDTH-2:0], w_ge};
  assign w_cnt_last = (r_cnt == c_cnt_w'(1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    w_launch   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        done = (r_state == S_DONE);
        if (start) begin
          w_launch   = 1'b1;
          w_state_nx = w_dvs_zero ? S_ZERO : S_RUN;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_cnt_last) begin
          w_state_nx = S_DONE;
        end
      end
      S_ZERO: begin
        busy       = 1'b1;
        w_state_nx = S_DONE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // For a zero divisor r_quo carries the raw dividend through to the remainder.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_launch) begin
      r_cnt   <= c_cnt_w'(WIDTH);
      r_rem   <= '0;
      r_quo   <= w_dvs_zero ? dividend : w_dvd_mag;
      r_dvs   <= w_dvs_mag;
      r_neg_q <= w_dvd_neg ^ w_dvs_neg;
      r_neg_r <= w_dvd_neg;
    end else if (r_state == S_RUN) begin
      r_cnt   <= r_cnt - c_cnt_w'(1);
      r_rem   <= w_rem_nx;
      r_quo   <= w_quo_nx;
    end
  end

  // Results change only on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (r_state == S_RUN && w_cnt_last) begin
      quotient    <= r_neg_q ? -w_quo_nx : w_quo_nx;
      remainder   <= r_neg_r ? -w_rem_nx : w_rem_nx;
      div_by_zero <= 1'b0;
    end else if (r_state == S_ZERO) begin
      quotient    <= '1;
      remainder   <= r_quo;
      div_by_zero <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_divider
//  Description : Scoreboard bench for mdu_divider (latency, results, handshake).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  mdu_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } res_t;

  res_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic res_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
    res_t m;
    m.q = q; m.r = r; m.dz = dz;
    return m;
  endfunction

  // Reference result from the language's own division operators.
  function automatic res_t model(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return mk('1, a, 1'b0 | 1'b1);
    if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return mk(32'h8000_0000, '0, 1'b0);
    if (sg) return mk(W'($signed(a) / $signed(b)), W'($signed(a) % $signed(b)), 1'b0);
    return mk(a / b, a % b, 1'b0);
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      res_t e;
      chk("done_expected", W'(sb.size() != 0), W'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", W'(div_by_zero), W'(e.dz));
      end
    end
  end

  task automatic run_op(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                        input res_t e, input bit pulses, input string tag);
    int lat;
    int bcnt;
    @(negedge clk);
    is_signed = sg; dividend = a; divisor = b; start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    lat = 1; bcnt = 0;
    start = 1'b0;
    dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom_range(0, 1));
    while (done !== 1'b1 && lat < 80) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
      start = pulses && (lat == 5 || lat == 20);
    end
    start = 1'b0;
    chk({tag, "_latency"}, W'(lat), (b == '0) ? W'(2) : W'(W + 1));
    chk({tag, "_busy_cycles"}, W'(bcnt), (b == '0) ? W'(1) : W'(W));
    chk({tag, "_busy_at_done"}, W'(busy), W'(0));
    @(negedge clk);
    chk({tag, "_done_pulse"}, W'(done), W'(0));
    chk({tag, "_q_held"}, quotient, e.q);
  endtask

  initial begin
    int lat;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sg;

    repeat (3) @(negedge clk);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_q", quotient, '0);
    chk("rst_r", remainder, '0);
    chk("rst_dz", W'(div_by_zero), W'(0));
    reset_n = 1'b1;

    run_op(1'b0, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0), 1'b0, "u100_7");
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0), 1'b0, "s_m7_2");
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2, mk(32'h7FFF_FFFC, 32'd1, 1'b0), 1'b0, "u_m7_2");
    run_op(1'b0, 32'd5, 32'd0, mk(32'hFFFF_FFFF, 32'd5, 1'b1), 1'b0, "u5_0");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h8000_0000, 32'd0, 1'b0), 1'b0, "s_ovf");
    run_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, mk(32'd1, 32'h7FFF_FFFF, 1'b0), 1'b0, "u_msb");
    run_op(1'b1, 32'hFFFF_FFFD, 32'd0, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1), 1'b0, "s_m3_0");
    run_op(1'b0, 32'd1000, 32'd10, mk(32'd100, 32'd0, 1'b0), 1'b1, "pulsed");

    for (int i = 0; i < 6; i++) begin
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 31);
      sg = 1'($urandom_range(0, 1));
      run_op(sg, a, b, model(sg, a, b), 1'b0, "rand");
    end

    // Start held high straight through DONE launches the next op with no gap.
    @(negedge clk);
    is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    sb.push_back(mk(32'd14, 32'd2, 1'b0));
    sb.push_back(mk(32'd3, 32'd0, 1'b0));
    @(negedge clk);
    dividend = 32'd9; divisor = 32'd3;
    lat = 1;
    while (done !== 1'b1 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_first_latency", W'(lat), W'(W + 1));
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    chk("b2b_no_gap_busy", W'(busy), W'(1));
    lat = 1;
    while (done !== 1'b1 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_second_latency", W'(lat), W'(W + 1));
    @(negedge clk);

    // Abort a run with reset at cycle 10; it must never report done.
    @(negedge clk);
    is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_done", W'(done), W'(0));
    chk("abort_q", quotient, '0);
    chk("abort_r", remainder, '0);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    run_op(1'b0, 32'd8, 32'd2, mk(32'd4, 32'd0, 1'b0), 1'b0, "u8_2");

    repeat (3) @(negedge clk);
    chk("sb_drained", W'(sb.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
